// File: rtl/vga_pattern_gen.sv
// VGA timing plus animated test pattern (bars, checker, gradient, solid) with scroll/pause.
// Latency: sync, video_active and colour are registered one clock after the hpos/vpos state.
// Backpressure: none; the raster runs free and only the animation state honours pause.
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int COLOR_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic [2:0]            speed,
  input  logic [3:0]            bit_sel,
  input  logic                  pause,
  output logic                  hsync,
  output logic                  vsync,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic                  video_active,
  output logic [7:0]            frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_FE     = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_CHECKER  = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_SOLID    = 2'd3
  } pat_e;

  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;
  logic [9:0]    offset;
  pat_e          mode_q;

  logic          frame_evt;
  logic          active;
  logic          in_hsync;
  logic          in_vsync;
  logic [9:0]    mx;
  logic [7:0]    y8;
  logic [3:0]    sel;
  logic [7:0]    ir;
  logic [7:0]    ig;
  logic [7:0]    ib;

  // Raster counters never stop, pause only affects animation state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos <= '0;
      vpos <= '0;
    end else if (hpos == H_LAST) begin
      hpos <= '0;
      vpos <= (vpos == V_LAST) ? '0 : vpos + VW'(1);
    end else begin
      hpos <= hpos + HW'(1);
    end
  end

  assign frame_evt = (hpos == H_LAST) && (vpos == V_FE);

  // Mode is latched only at the frame event so a change never tears a visible frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset    <= '0;
      frame_cnt <= '0;
      mode_q    <= PAT_BARS;
    end else if (frame_evt && !pause) begin
      offset    <= offset + 10'(speed);
      frame_cnt <= frame_cnt + 8'd1;
      mode_q    <= pat_e'(mode);
    end
  end

  assign active   = (hpos < H_ACT) && (vpos < V_ACT);
  assign in_hsync = (hpos >= HS_BEGIN) && (hpos <= HS_END);
  assign in_vsync = (vpos >= VS_BEGIN) && (vpos <= VS_END);
  assign mx       = 10'(hpos) + offset;
  assign y8       = 8'(vpos);
  assign sel      = (bit_sel > 4'd9) ? 4'd9 : bit_sel;

  always_comb begin
    ir = 8'h00;
    ig = 8'h00;
    ib = 8'h00;
    case (mode_q)
      PAT_BARS: begin
        ir = mx[sel] ? 8'hFF : 8'h00;
        ig = mx[6]   ? 8'hFF : 8'h00;
        ib = mx[7]   ? 8'hFF : 8'h00;
      end
      PAT_CHECKER: begin
        ir = (mx[5] ^ y8[5]) ? 8'hFF : 8'h00;
        ig = ir;
        ib = ir;
      end
      PAT_GRADIENT: begin
        ir = mx[7:0];
        ig = y8;
        ib = mx[7:0] ^ y8;
      end
      PAT_SOLID: begin
        ir = frame_cnt[0] ? 8'hFF : 8'h00;
        ig = frame_cnt[1] ? 8'hFF : 8'h00;
        ib = frame_cnt[2] ? 8'hFF : 8'h00;
      end
      default: begin
        ir = 8'h00;
        ig = 8'h00;
        ib = 8'h00;
      end
    endcase
  end

  // Keep the top COLOR_BITS of each 8-bit intensity; blanking forces black.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync        <= ~SYNC_POL;
      vsync        <= ~SYNC_POL;
      video_active <= 1'b0;
      r            <= '0;
      g            <= '0;
      b            <= '0;
    end else begin
      hsync        <= in_hsync ? SYNC_POL : ~SYNC_POL;
      vsync        <= in_vsync ? SYNC_POL : ~SYNC_POL;
      video_active <= active;
      r            <= active ? COLOR_BITS'(ir >> (8 - COLOR_BITS)) : '0;
      g            <= active ? COLOR_BITS'(ig >> (8 - COLOR_BITS)) : '0;
      b            <= active ? COLOR_BITS'(ib >> (8 - COLOR_BITS)) : '0;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench: two pattern generators (active-low 2-bit, active-high 4-bit) on reduced rasters,
// checked against a frame-arithmetic reference model.
module tb_vga_pattern_gen;

  localparam int HA_A = 64, HF_A = 2, HS_A = 4, HB_A = 2;
  localparam int VA_A = 36, VF_A = 1, VS_A = 2, VB_A = 1;
  localparam int HA_B = 8,  HF_B = 1, HS_B = 2, HB_B = 1;
  localparam int VA_B = 4,  VF_B = 1, VS_B = 1, VB_B = 1;
  localparam int HT_A = 72, FR_A = 72 * 40;
  localparam int HT_B = 12, FR_B = 12 * 7;

  localparam int P_HA [2] = '{HA_A, HA_B};
  localparam int P_HF [2] = '{HF_A, HF_B};
  localparam int P_HS [2] = '{HS_A, HS_B};
  localparam int P_HB [2] = '{HB_A, HB_B};
  localparam int P_VA [2] = '{VA_A, VA_B};
  localparam int P_VF [2] = '{VF_A, VF_B};
  localparam int P_VS [2] = '{VS_A, VS_B};
  localparam int P_VB [2] = '{VB_A, VB_B};
  localparam int P_POL[2] = '{0, 1};
  localparam int P_CB [2] = '{2, 4};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic [2:0] speed;
  logic [3:0] bit_sel;
  logic       pause;

  logic       hsync_a, vsync_a, video_active_a;
  logic [1:0] r_a, g_a, b_a;
  logic [7:0] frame_cnt_a;
  logic       hsync_b, vsync_b, video_active_b;
  logic [3:0] r_b, g_b, b_b;
  logic [7:0] frame_cnt_b;

  logic [34:0] act_v [2];
  logic [34:0] exp_v [2];
  int m_t [2], m_off [2], m_fc [2], m_mq [2], m_lastmx [2];
  logic m_lastact [2];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_ACTIVE(HA_A), .H_FP(HF_A), .H_SYNC(HS_A), .H_BP(HB_A),
    .V_ACTIVE(VA_A), .V_FP(VF_A), .V_SYNC(VS_A), .V_BP(VB_A),
    .SYNC_POL(1'b0), .COLOR_BITS(2)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .speed(speed), .bit_sel(bit_sel), .pause(pause),
    .hsync(hsync_a), .vsync(vsync_a), .r(r_a), .g(g_a), .b(b_a),
    .video_active(video_active_a), .frame_cnt(frame_cnt_a)
  );

  vga_pattern_gen #(
    .H_ACTIVE(HA_B), .H_FP(HF_B), .H_SYNC(HS_B), .H_BP(HB_B),
    .V_ACTIVE(VA_B), .V_FP(VF_B), .V_SYNC(VS_B), .V_BP(VB_B),
    .SYNC_POL(1'b1), .COLOR_BITS(4)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .speed(speed), .bit_sel(bit_sel), .pause(pause),
    .hsync(hsync_b), .vsync(vsync_b), .r(r_b), .g(g_b), .b(b_b),
    .video_active(video_active_b), .frame_cnt(frame_cnt_b)
  );

  assign act_v[0] = {hsync_a, vsync_a, video_active_a, 6'd0, r_a, 6'd0, g_a, 6'd0, b_a, frame_cnt_a};
  assign act_v[1] = {hsync_b, vsync_b, video_active_b, 4'd0, r_b, 4'd0, g_b, 4'd0, b_b, frame_cnt_b};

  function automatic logic [7:0] scale(input logic [7:0] i, input int cb);
    return i >> (8 - cb);
  endfunction

  // Reference: raster position is cycle count mod line/frame size; animation advances once per frame.
  task automatic model_step(input int k);
    int ht, vt, hp, vp, mx, y, bs;
    logic act, hs, vs, pol, c;
    logic [7:0] ir, ig, ib;
    ht  = P_HA[k] + P_HF[k] + P_HS[k] + P_HB[k];
    vt  = P_VA[k] + P_VF[k] + P_VS[k] + P_VB[k];
    pol = (P_POL[k] != 0);
    if (rst_n !== 1'b1) begin
      m_t[k] = 0; m_off[k] = 0; m_fc[k] = 0; m_mq[k] = 0;
      m_lastmx[k] = 0; m_lastact[k] = 1'b0;
      exp_v[k] = {~pol, ~pol, 33'd0};
    end else begin
      hp  = m_t[k] % ht;
      vp  = (m_t[k] / ht) % vt;
      act = (hp < P_HA[k]) && (vp < P_VA[k]);
      hs  = (hp >= P_HA[k] + P_HF[k] && hp < P_HA[k] + P_HF[k] + P_HS[k]) ? pol : ~pol;
      vs  = (vp >= P_VA[k] + P_VF[k] && vp < P_VA[k] + P_VF[k] + P_VS[k]) ? pol : ~pol;
      mx  = (hp + m_off[k]) % 1024;
      y   = vp % 1024;
      bs  = (int'(bit_sel) > 9) ? 9 : int'(bit_sel);
      ir = 8'h00; ig = 8'h00; ib = 8'h00;
      case (m_mq[k])
        0: begin
          ir = (((mx >> bs) & 1) != 0) ? 8'hFF : 8'h00;
          ig = (((mx / 64) % 2) != 0)  ? 8'hFF : 8'h00;
          ib = (((mx / 128) % 2) != 0) ? 8'hFF : 8'h00;
        end
        1: begin
          c  = ((mx / 32) % 2) != ((y / 32) % 2);
          ir = c ? 8'hFF : 8'h00; ig = ir; ib = ir;
        end
        2: begin
          ir = 8'(mx % 256); ig = 8'(y % 256); ib = 8'(mx % 256) ^ 8'(y % 256);
        end
        default: begin
          ir = ((m_fc[k] % 2) != 0)       ? 8'hFF : 8'h00;
          ig = (((m_fc[k] / 2) % 2) != 0) ? 8'hFF : 8'h00;
          ib = (((m_fc[k] / 4) % 2) != 0) ? 8'hFF : 8'h00;
        end
      endcase
      if (!act) begin
        ir = 8'h00; ig = 8'h00; ib = 8'h00;
      end
      if (hp == ht - 1 && vp == P_VA[k] - 1 && !pause) begin
        m_off[k] = (m_off[k] + int'(speed)) % 1024;
        m_fc[k]  = (m_fc[k] + 1) % 256;
        m_mq[k]  = int'(mode);
      end
      exp_v[k] = {hs, vs, act, scale(ir, P_CB[k]), scale(ig, P_CB[k]), scale(ib, P_CB[k]), 8'(m_fc[k])};
      m_lastmx[k]  = mx;
      m_lastact[k] = act;
      m_t[k]       = m_t[k] + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mode = 2'd0; speed = 3'd0; bit_sel = 4'd0; pause = 1'b0; rst_n = 1'b0;
    tick();
    n_checks++;
    if ({hsync_a, vsync_a, video_active_a, r_a, g_a, b_a, frame_cnt_a} !== {3'b110, 6'd0, 8'd0}) begin
      $display("FAIL reset_a: got %h want %h", {hsync_a, vsync_a, video_active_a, r_a, g_a, b_a, frame_cnt_a}, {3'b110, 6'd0, 8'd0});
    end else n_pass++;
    n_checks++;
    if ({hsync_b, vsync_b, video_active_b, r_b, g_b, b_b, frame_cnt_b} !== 23'd0) begin
      $display("FAIL reset_b: got %h want 0", {hsync_b, vsync_b, video_active_b, r_b, g_b, b_b, frame_cnt_b});
    end else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({video_active_a, video_active_b, hsync_a, hsync_b} !== 4'b1110) begin
      $display("FAIL first_pixel: got %b want 1110", {video_active_a, video_active_b, hsync_a, hsync_b});
    end else n_pass++;
  endtask

  task automatic test_timing();
    int va_cnt = 0, hs_cnt = 0, vs_cnt = 0, first_hs = -1, first_vs = -1;
    mode = 2'd0; speed = 3'd0; pause = 1'b0;
    do_reset();
    for (int c = 0; c < FR_A; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_v[k] !== exp_v[k]) $display("FAIL timing inst%0d cyc%0d: got %h want %h", k, c, act_v[k], exp_v[k]);
        else n_pass++;
      end
      if (video_active_a) va_cnt++;
      if (!hsync_a) begin hs_cnt++; if (first_hs < 0) first_hs = c; end
      if (!vsync_a) begin vs_cnt++; if (first_vs < 0) first_vs = c; end
      bit_sel = 4'($urandom);
    end
    n_checks++;
    if (va_cnt != 64 * 36) $display("FAIL active_count: got %0d want %0d", va_cnt, 64 * 36); else n_pass++;
    n_checks++;
    if (hs_cnt != 4 * 40) $display("FAIL hsync_count: got %0d want %0d", hs_cnt, 4 * 40); else n_pass++;
    n_checks++;
    if (vs_cnt != 2 * 72) $display("FAIL vsync_count: got %0d want %0d", vs_cnt, 2 * 72); else n_pass++;
    n_checks++;
    if (first_hs != 66) $display("FAIL hsync_first: got %0d want 66", first_hs); else n_pass++;
    n_checks++;
    if (first_vs != 37 * 72) $display("FAIL vsync_first: got %0d want %0d", first_vs, 37 * 72); else n_pass++;
  endtask

  task automatic test_scroll();
    mode = 2'd0; speed = 3'd3; bit_sel = 4'd4; pause = 1'b0;
    do_reset();
    for (int c = 0; c <= 2 * FR_A + 10; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_v[k] !== exp_v[k]) $display("FAIL scroll inst%0d cyc%0d: got %h want %h", k, c, act_v[k], exp_v[k]);
        else n_pass++;
      end
      if (c == 2 * FR_A) begin
        n_checks++;
        if ({r_a, frame_cnt_a} !== {2'b00, 8'd2}) $display("FAIL scroll_px0: got %h want %h", {r_a, frame_cnt_a}, {2'b00, 8'd2});
        else n_pass++;
      end
      if (c == 2 * FR_A + 10) begin
        n_checks++;
        if (r_a !== 2'b11) $display("FAIL scroll_px10: got %b want 11", r_a); else n_pass++;
      end
    end
  endtask

  task automatic test_mode_change();
    mode = 2'd0; speed = 3'd0; pause = 1'b0; bit_sel = 4'($urandom);
    do_reset();
    for (int c = 0; c <= FR_A + 32 * HT_A + 32; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_v[k] !== exp_v[k]) $display("FAIL mode_chg inst%0d cyc%0d: got %h want %h", k, c, act_v[k], exp_v[k]);
        else n_pass++;
      end
      if (c == 20 * HT_A) mode = 2'd1;
      if (c == 30 * HT_A + 48) begin
        n_checks++;
        if ({g_a, b_a} !== 4'b0000) $display("FAIL still_bars: got %b want 0000", {g_a, b_a}); else n_pass++;
      end
      if (c == FR_A + 32) begin
        n_checks++;
        if ({r_a, g_a, b_a} !== 6'b111111) $display("FAIL checker_32_0: got %b want 111111", {r_a, g_a, b_a}); else n_pass++;
      end
      if (c == FR_A + 32 * HT_A + 32) begin
        n_checks++;
        if ({r_a, g_a, b_a} !== 6'b000000) $display("FAIL checker_32_32: got %b want 000000", {r_a, g_a, b_a}); else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    mode = 2'($urandom); speed = 3'($urandom); pause = 1'b0;
    do_reset();
    for (int c = 0; c < 2 * FR_A; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_v[k] !== exp_v[k]) $display("FAIL random inst%0d cyc%0d: got %h want %h", k, c, act_v[k], exp_v[k]);
        else n_pass++;
      end
      bit_sel = 4'($urandom);
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 99) == 0) speed = 3'($urandom);
      if ($urandom_range(0, 499) == 0) pause = ~pause;
      // Next edge is a frame event for u_b: change inputs right on it.
      if (m_t[1] % FR_B == (VA_B - 1) * HT_B + HT_B - 1) begin
        mode = 2'($urandom); speed = 3'($urandom);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_pause_wrap();
    logic [7:0] prev;
    logic saw_wrap = 1'b0;
    mode = 2'd3; speed = 3'($urandom); pause = 1'b0;
    do_reset();
    for (int c = 0; c < 10 * FR_B; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_v[k] !== exp_v[k]) $display("FAIL pause_pre inst%0d cyc%0d: got %h want %h", k, c, act_v[k], exp_v[k]);
        else n_pass++;
      end
    end
    pause = 1'b1;
    tick();
    n_checks++;
    if ({frame_cnt_b, r_b, g_b, b_b} !== {8'd10, 12'h0F0}) $display("FAIL pause_start: got %h want %h", {frame_cnt_b, r_b, g_b, b_b}, {8'd10, 12'h0F0});
    else n_pass++;
    for (int c = 0; c < 3 * FR_B; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_v[k] !== exp_v[k]) $display("FAIL paused inst%0d cyc%0d: got %h want %h", k, c, act_v[k], exp_v[k]);
        else n_pass++;
      end
    end
    n_checks++;
    if ({frame_cnt_b, r_b, g_b, b_b} !== {8'd10, 12'h0F0}) $display("FAIL pause_hold: got %h want %h", {frame_cnt_b, r_b, g_b, b_b}, {8'd10, 12'h0F0});
    else n_pass++;
    pause = 1'b0;
    prev = frame_cnt_b;
    for (int c = 0; c < 250 * FR_B && !saw_wrap; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_v[k] !== exp_v[k]) $display("FAIL resume inst%0d cyc%0d: got %h want %h", k, c, act_v[k], exp_v[k]);
        else n_pass++;
      end
      if (prev == 8'd255 && frame_cnt_b == 8'd0) saw_wrap = 1'b1;
      prev = frame_cnt_b;
    end
    n_checks++;
    if (saw_wrap !== 1'b1) $display("FAIL frame_wrap: got %b want 1", saw_wrap); else n_pass++;
  endtask

  task automatic test_bit_sel_clamp();
    mode = 2'd0; speed = 3'd7; pause = 1'b0; bit_sel = 4'd15;
    do_reset();
    for (int c = 0; c < 80 * FR_B; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_v[k] !== exp_v[k]) $display("FAIL clamp inst%0d cyc%0d: got %h want %h", k, c, act_v[k], exp_v[k]);
        else n_pass++;
      end
      if (m_lastact[1]) begin
        n_checks++;
        if (r_b !== ((((m_lastmx[1] >> 9) & 1) != 0) ? 4'hF : 4'h0))
          $display("FAIL clamp_red cyc%0d: got %h mx %0d", c, r_b, m_lastmx[1]);
        else n_pass++;
      end
      bit_sel = 4'($urandom_range(9, 15));
    end
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      for (int c = 0; c < 2 * FR_B; c++) begin
        tick();
        if (!m_lastact[0]) begin
          n_checks++;
          if ({r_a, g_a, b_a} !== 6'd0) $display("FAIL blank_a mode%0d: got %h want 0", m, {r_a, g_a, b_a}); else n_pass++;
        end
        if (!m_lastact[1]) begin
          n_checks++;
          if ({r_b, g_b, b_b} !== 12'd0) $display("FAIL blank_b mode%0d: got %h want 0", m, {r_b, g_b, b_b}); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_gradient();
    mode = 2'd2; speed = 3'($urandom_range(1, 7)); pause = 1'b0;
    do_reset();
    for (int c = 0; c < 20 * FR_B; c++) begin
      tick();
      n_checks++;
      if (act_v[1] !== exp_v[1]) $display("FAIL grad_vec cyc%0d: got %h want %h", c, act_v[1], exp_v[1]);
      else n_pass++;
      if (m_lastact[1] && c >= FR_B) begin
        n_checks++;
        if (r_b !== 4'((m_lastmx[1] % 256) / 16)) $display("FAIL grad_red cyc%0d: got %h mx %0d", c, r_b, m_lastmx[1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    int target;
    mode = 2'($urandom); speed = 3'($urandom); pause = 1'b0;
    do_reset();
    target = FR_A + 10 * HT_A + 68;
    for (int c = 0; c < 2 * FR_A && m_t[0] != target; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_v[k] !== exp_v[k]) $display("FAIL pre_arst inst%0d cyc%0d: got %h want %h", k, c, act_v[k], exp_v[k]);
        else n_pass++;
      end
    end
    n_checks++;
    if ({hsync_a, frame_cnt_a} !== {1'b0, 8'd1}) $display("FAIL arst_setup: got %h want %h", {hsync_a, frame_cnt_a}, {1'b0, 8'd1});
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({hsync_a, vsync_a, video_active_a, r_a, g_a, b_a, frame_cnt_a} !== {3'b110, 6'd0, 8'd0})
      $display("FAIL arst_a: got %h want %h", {hsync_a, vsync_a, video_active_a, r_a, g_a, b_a, frame_cnt_a}, {3'b110, 6'd0, 8'd0});
    else n_pass++;
    n_checks++;
    if ({hsync_b, vsync_b, video_active_b, r_b, g_b, b_b, frame_cnt_b} !== 23'd0)
      $display("FAIL arst_b: got %h want 0", {hsync_b, vsync_b, video_active_b, r_b, g_b, b_b, frame_cnt_b});
    else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < HT_A + 2; c++) begin
      tick();
      if (c == 0) begin
        n_checks++;
        if ({video_active_a, hsync_a} !== 2'b11) $display("FAIL arst_restart: got %b want 11", {video_active_a, hsync_a});
        else n_pass++;
      end
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_v[k] !== exp_v[k]) $display("FAIL post_arst inst%0d cyc%0d: got %h want %h", k, c, act_v[k], exp_v[k]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_scroll();
    test_mode_change();
    test_random();
    test_pause_wrap();
    test_bit_sel_clamp();
    test_gradient();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
